// File: rtl/fwd_hazard_unit_if.sv
// Bundle of pipeline-side signals seen by the forwarding / hazard unit.
// The pipeline drives through the master modport and the unit answers through the slave modport.
interface fwd_hazard_unit_if #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC-1:0]    id_src_valid;
  logic [NUM_SRC*AW-1:0] id_src_addr;
  logic [NUM_SRC*AW-1:0] ex_src_addr;
  logic [AW-1:0]         ex_rd;
  logic                  ex_memread;
  logic [AW-1:0]         mem_rd;
  logic                  mem_regwrite;
  logic [AW-1:0]         wb_rd;
  logic                  wb_regwrite;
  logic                  mdu_issue;
  logic [AW-1:0]         mdu_rd;
  logic [2*NUM_SRC-1:0]  fwd_sel;
  logic                  stall;
  logic [1:0]            stall_cause;
  logic                  mdu_busy;
  logic                  mdu_wb_valid;
  logic [AW-1:0]         mdu_wb_rd;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_src_valid, id_src_addr, ex_src_addr, ex_rd, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, mdu_issue, mdu_rd,
    input  fwd_sel, stall, stall_cause, mdu_busy, mdu_wb_valid, mdu_wb_rd,
           stall_count
  );

  modport slave (
    input  id_src_valid, id_src_addr, ex_src_addr, ex_rd, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, mdu_issue, mdu_rd,
    output fwd_sel, stall, stall_cause, mdu_busy, mdu_wb_valid, mdu_wb_rd,
           stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Per-operand EX forwarding, ID-stage load-use / MDU hazard detection with stall generation,
// a single-entry MDU scoreboard with latency countdown, and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  fwd_hazard_unit_if.slave   bus
);

  logic                 busy_q, busy_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        prd_q, prd_d;
  logic [CNT_W-1:0]     scnt_q, scnt_d;

  logic [2*NUM_SRC-1:0] fwd_sel_s;
  logic                 lu_s, raw_s, bh_s, stall_s;
  logic [1:0]           cause_s;
  logic                 wb_valid_s;

  // Operand forwarding: EX/MEM beats MEM/WB, register 0 never forwards
  always_comb begin
    fwd_sel_s = {(2*NUM_SRC){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.mem_regwrite && (bus.mem_rd != {AW{1'b0}}) &&
          (bus.mem_rd == bus.ex_src_addr[i*AW +: AW])) begin
        fwd_sel_s[2*i +: 2] = 2'b10;
      end else if (bus.wb_regwrite && (bus.wb_rd != {AW{1'b0}}) &&
                   (bus.wb_rd == bus.ex_src_addr[i*AW +: AW])) begin
        fwd_sel_s[2*i +: 2] = 2'b01;
      end else begin
        fwd_sel_s[2*i +: 2] = 2'b00;
      end
    end
  end

  // Hazard terms and prioritised stall cause
  always_comb begin
    lu_s  = 1'b0;
    raw_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_valid[i] && (bus.id_src_addr[i*AW +: AW] != {AW{1'b0}})) begin
        if (bus.ex_memread && (bus.ex_rd == bus.id_src_addr[i*AW +: AW])) begin
          lu_s = 1'b1;
        end else begin
          lu_s = lu_s;
        end
        if (busy_q && (prd_q == bus.id_src_addr[i*AW +: AW])) begin
          raw_s = 1'b1;
        end else begin
          raw_s = raw_s;
        end
      end else begin
        lu_s  = lu_s;
        raw_s = raw_s;
      end
    end
    bh_s    = bus.mdu_issue && busy_q;
    stall_s = lu_s || raw_s || bh_s;
    if (lu_s) begin
      cause_s = 2'b01;
    end else if (raw_s) begin
      cause_s = 2'b10;
    end else if (bh_s) begin
      cause_s = 2'b11;
    end else begin
      cause_s = 2'b00;
    end
  end

  // Scoreboard next state; an issue can only be accepted when the unit is idle and nothing stalls
  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    prd_d      = prd_q;
    wb_valid_s = busy_q && (cnt_q == 4'd1);
    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (bus.mdu_issue && !stall_s) begin
      busy_d = 1'b1;
      cnt_d  = 4'(MDU_LAT);
      prd_d  = bus.mdu_rd;
    end else begin
      busy_d = 1'b0;
    end
    if (stall_s && (scnt_q != {CNT_W{1'b1}})) begin
      scnt_d = scnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      scnt_d = scnt_q;
    end
  end

  // State registers; asynchronous reset aborts any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      prd_q  <= {AW{1'b0}};
      scnt_q <= {CNT_W{1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      prd_q  <= prd_d;
      scnt_q <= scnt_d;
    end
  end

  assign bus.fwd_sel      = fwd_sel_s;
  assign bus.stall        = stall_s;
  assign bus.stall_cause  = cause_s;
  assign bus.mdu_busy     = busy_q;
  assign bus.mdu_wb_valid = wb_valid_s;
  assign bus.mdu_wb_rd    = wb_valid_s ? prd_q : {AW{1'b0}};
  assign bus.stall_count  = scnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding, load-use, MDU scoreboard, priority, reset, saturation.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .CNT_W(16)) bus ();
  fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .CNT_W(4))  bus2 ();

  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .MDU_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .MDU_LAT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.id_src_valid = 2'b00;  bus.id_src_addr = 10'd0;  bus.ex_src_addr = 10'd0;
    bus.ex_rd = 5'd0;          bus.ex_memread = 1'b0;    bus.mem_rd = 5'd0;
    bus.mem_regwrite = 1'b0;   bus.wb_rd = 5'd0;         bus.wb_regwrite = 1'b0;
    bus.mdu_issue = 1'b0;      bus.mdu_rd = 5'd0;
    bus2.id_src_valid = 2'b00; bus2.id_src_addr = 10'd0; bus2.ex_src_addr = 10'd0;
    bus2.ex_rd = 5'd0;         bus2.ex_memread = 1'b0;   bus2.mem_rd = 5'd0;
    bus2.mem_regwrite = 1'b0;  bus2.wb_rd = 5'd0;        bus2.wb_regwrite = 1'b0;
    bus2.mdu_issue = 1'b0;     bus2.mdu_rd = 5'd0;

    // reset state, forwarding still live during reset
    #1 reset = 1'b1;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3; bus.ex_src_addr = {5'd0, 5'd3};
    #1;
    chk("rst_busy", 32'(bus.mdu_busy), 32'd0);
    chk("rst_wbv", 32'(bus.mdu_wb_valid), 32'd0);
    chk("rst_wbrd", 32'(bus.mdu_wb_rd), 32'd0);
    chk("rst_cnt", 32'(bus.stall_count), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_fwd", 32'(bus.fwd_sel), 32'b0010);
    tick(); tick();
    reset = 1'b0;

    // ALU chain forwarding
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd2; bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd2;
    bus.ex_src_addr = {5'd2, 5'd2};
    #1 chk("fwd_mem_both", 32'(bus.fwd_sel), 32'b1010);
    bus.mem_rd = 5'd0;
    #1 chk("fwd_wb_both", 32'(bus.fwd_sel), 32'b0101);
    bus.wb_rd = 5'd0;
    #1 chk("fwd_none", 32'(bus.fwd_sel), 32'b0000);
    chk("fwd_none_stall", 32'(bus.stall), 32'd0);
    bus.mem_rd = 5'd3; bus.wb_rd = 5'd2; bus.ex_src_addr = {5'd3, 5'd2};
    #1 chk("fwd_mixed", 32'(bus.fwd_sel), 32'b1001);
    bus.mem_regwrite = 1'b0; bus.wb_rd = 5'd3;
    #1 chk("fwd_memwr_off", 32'(bus.fwd_sel), 32'b0100);
    bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;
    tick();

    // load-use
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_src_valid = 2'b01; bus.id_src_addr = {5'd0, 5'd5};
    #1 chk("lu_stall", 32'(bus.stall), 32'd1);
    chk("lu_cause", 32'(bus.stall_cause), 32'b01);
    chk("lu_cnt0", 32'(bus.stall_count), 32'(exp_cnt));
    tick(); exp_cnt++;
    chk("lu_cnt1", 32'(bus.stall_count), 32'(exp_cnt));
    tick(); exp_cnt++;
    chk("lu_cnt2", 32'(bus.stall_count), 32'(exp_cnt));
    bus.id_src_valid = 2'b00;
    #1 chk("lu_invalid_stall", 32'(bus.stall), 32'd0);
    chk("lu_invalid_cause", 32'(bus.stall_cause), 32'b00);
    bus.ex_rd = 5'd0; bus.id_src_valid = 2'b11; bus.id_src_addr = 10'd0;
    #1 chk("lu_r0_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("lu_cnt_hold", 32'(bus.stall_count), 32'(exp_cnt));
    bus.ex_memread = 1'b0; bus.id_src_valid = 2'b00;

    // MDU RAW on r7
    bus.mdu_issue = 1'b1; bus.mdu_rd = 5'd7;
    #1 chk("mdu_issue_nostall", 32'(bus.stall), 32'd0);
    tick();
    bus.mdu_issue = 1'b0; bus.id_src_valid = 2'b01; bus.id_src_addr = {5'd0, 5'd7};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("raw_stall_%0d", k), 32'(bus.stall), 32'd1);
      chk($sformatf("raw_cause_%0d", k), 32'(bus.stall_cause), 32'b10);
      chk($sformatf("raw_busy_%0d", k), 32'(bus.mdu_busy), 32'd1);
      chk($sformatf("raw_wbv_%0d", k), 32'(bus.mdu_wb_valid), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("raw_wbrd_%0d", k), 32'(bus.mdu_wb_rd), (k == 3) ? 32'd7 : 32'd0);
      tick(); exp_cnt++;
    end
    chk("raw_done_stall", 32'(bus.stall), 32'd0);
    chk("raw_done_busy", 32'(bus.mdu_busy), 32'd0);
    chk("raw_done_wbv", 32'(bus.mdu_wb_valid), 32'd0);
    chk("raw_cnt", 32'(bus.stall_count), 32'(exp_cnt));
    bus.id_src_valid = 2'b00;

    // structural hazard and priority: first op r9, second issue r10 held
    bus.mdu_issue = 1'b1; bus.mdu_rd = 5'd9;
    tick();
    bus.mdu_rd = 5'd10;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_src_valid = 2'b01; bus.id_src_addr = {5'd0, 5'd5};
    #1 chk("prio_lu_over_busy", 32'(bus.stall_cause), 32'b01);
    tick(); exp_cnt++;
    bus.ex_memread = 1'b0; bus.id_src_valid = 2'b00;
    #1 chk("busy_stall", 32'(bus.stall), 32'd1);
    chk("busy_cause", 32'(bus.stall_cause), 32'b11);
    tick(); exp_cnt++;
    bus.id_src_valid = 2'b10; bus.id_src_addr = {5'd9, 5'd0};
    #1 chk("prio_raw_over_busy", 32'(bus.stall_cause), 32'b10);
    tick(); exp_cnt++;
    bus.id_src_valid = 2'b00;
    #1 chk("wb_cycle_busy_cause", 32'(bus.stall_cause), 32'b11);
    chk("wb_cycle_wbv", 32'(bus.mdu_wb_valid), 32'd1);
    chk("wb_cycle_wbrd", 32'(bus.mdu_wb_rd), 32'd9);
    tick(); exp_cnt++;
    chk("second_issue_free", 32'(bus.stall), 32'd0);
    chk("second_issue_idle", 32'(bus.mdu_busy), 32'd0);
    tick();
    bus.mdu_issue = 1'b0;
    chk("second_accepted", 32'(bus.mdu_busy), 32'd1);
    bus.id_src_valid = 2'b01; bus.id_src_addr = {5'd0, 5'd10};
    #1 chk("second_raw_cause", 32'(bus.stall_cause), 32'b10);
    chk("second_cnt", 32'(bus.stall_count), 32'(exp_cnt));
    bus.id_src_valid = 2'b00;
    tick(); tick();

    // asynchronous reset with the counter at 2
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 32'(bus.mdu_busy), 32'd0);
    chk("rstmid_wbv", 32'(bus.mdu_wb_valid), 32'd0);
    chk("rstmid_cnt", 32'(bus.stall_count), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstmid_nowb_%0d", k), 32'(bus.mdu_wb_valid), 32'd0);
      chk($sformatf("rstmid_idle_%0d", k), 32'(bus.mdu_busy), 32'd0);
    end

    // saturation on the 4-bit counter instance
    bus2.ex_memread = 1'b1; bus2.ex_rd = 5'd5; bus2.id_src_valid = 2'b01; bus2.id_src_addr = {5'd0, 5'd5};
    #1 chk("sat_stall", 32'(bus2.stall), 32'd1);
    chk("sat_start", 32'(bus2.stall_count), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat_14", 32'(bus2.stall_count), 32'd14);
      if (k == 15) chk("sat_15", 32'(bus2.stall_count), 32'd15);
    end
    chk("sat_20", 32'(bus2.stall_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Resolves operand forwarding independently for NUM_SRC source operands in the EX stage.
- Detects load-use and multi-cycle-divider/multiplier (MDU) RAW hazards in the ID stage and generates the pipeline stall.
- Owns a single-entry MDU scoreboard with latency countdown and a saturating stall-cycle performance counter.

Parameters:
- AW, 5, register address width
- NUM_SRC, 2, number of source operands per instruction
- MDU_LAT, 4, MDU result latency in cycles after issue acceptance (legal range 2..15)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- id_src_valid  in  NUM_SRC  ID-stage operand i is read
- id_src_addr  in  NUM_SRC*AW  ID-stage operand addresses; operand i in bits [i*AW +: AW]
- ex_src_addr  in  NUM_SRC*AW  ID/EX operand addresses, used for forwarding
- ex_rd  in  AW  ID/EX destination register
- ex_memread  in  1  ID/EX instruction is a load
- mem_rd  in  AW  EX/MEM destination register
- mem_regwrite  in  1  EX/MEM writes the register file
- wb_rd  in  AW  MEM/WB destination register
- wb_regwrite  in  1  MEM/WB writes the register file
- mdu_issue  in  1  ID-stage instruction is an MDU op
- mdu_rd  in  AW  destination register of the issuing MDU op
- fwd_sel  out  2*NUM_SRC  per-operand mux select, bits [2i+1:2i]
- stall  out  1  freeze PC and IF/ID; bubble into ID/EX
- stall_cause  out  2  00 none, 01 load-use, 10 MDU RAW, 11 MDU busy
- mdu_busy  out  1  MDU op in flight
- mdu_wb_valid  out  1  MDU result writes the register file this cycle
- mdu_wb_rd  out  AW  destination of the MDU writeback
- stall_count  out  CNT_W  number of stalled cycles since reset

Behaviour:
- Reset values: busy=0, counter=0, pending rd=0, stall_count=0.
  - Consequently mdu_busy=0, mdu_wb_valid=0, mdu_wb_rd=0.
  - fwd_sel and stall remain purely combinational during reset.
- Reset asserted mid-MDU-operation aborts it; no mdu_wb_valid pulse is produced.
- Forwarding is combinational, zero latency, and evaluated per operand independently; multiple operands may forward in the same cycle.
  - fwd_sel=10 if mem_regwrite && mem_rd!=0 && mem_rd==src.
  - Else fwd_sel=01 if wb_regwrite && wb_rd!=0 && wb_rd==src.
  - Else fwd_sel=00.
  - EX/MEM always wins over MEM/WB.
- Address 0 never forwards and never causes a stall.
- Hazard terms are combinational, each requiring operand i valid and addr!=0:
  - Load-use: ex_memread && ex_rd==id_src_addr[i].
  - MDU RAW: mdu_busy && pending rd==id_src_addr[i].
  - Busy: mdu_issue && mdu_busy.
- stall is the OR of all three terms. When more than one is true, stall_cause priority is load-use > MDU RAW > busy.
- MDU issue acceptance occurs when mdu_issue && !stall at a rising edge.
  - At that edge: busy<=1, counter<=MDU_LAT, pending rd<=mdu_rd.
  - Issue with mdu_rd=0 is accepted normally; it simply never creates a RAW stall.
- While busy, the counter decrements by 1 each edge.
- mdu_wb_valid = busy && counter==1, so it is high exactly during the MDU_LAT-th cycle after acceptance. mdu_wb_rd = pending rd while valid, else 0.
- At the edge ending the writeback cycle, busy<=0.
  - A new issue in that same cycle still sees busy=1 and stalls.
  - It is accepted in the following cycle.
- RAW stall on the pending rd persists through the writeback cycle. The dependent instruction proceeds the cycle after, reading the written register file.
- stall_count increments by 1 on every edge where stall=1 and saturates at all-ones.
- Register-file write-port arbitration between MDU writeback and MEM/WB is external to this block.

Test Plan:
- ALU chain: mem_regwrite=1, mem_rd=2, wb_regwrite=1, wb_rd=2, ex_src_addr={2,2} -> fwd_sel=1010; set mem_rd=0 -> fwd_sel=0101; wb_rd=0 also -> 0000, stall=0.
- Load-use: ex_memread=1, ex_rd=5, id_src_valid=01, id_src_addr[0]=5 -> stall=1, cause=01, stall_count +1 per cycle; id_src_valid=00 -> stall=0.
- MDU RAW: issue mdu_rd=7 at edge T with MDU_LAT=4, then ID reads r7 -> stall=1, cause=10 for cycles T..T+3. mdu_wb_valid=1 and mdu_wb_rd=7 only in cycle T+3; stall=0 and mdu_busy=0 at T+4.
- Structural and priority: mdu_issue=1 while busy -> cause=11, issue not accepted; simultaneously set load-use -> cause=01. Second issue accepted the cycle after the first writeback.
- Reset mid-op: assert reset at count 2 -> mdu_busy, mdu_wb_valid, stall_count all 0 immediately (asynchronous). No writeback pulse after reset is released.
- Saturation: CNT_W=4, hold stall 20 cycles -> stall_count sticks at 15.
